// File: rtl/alu_multicycle_if.sv
// Handshake/data bus for alu_multicycle.
// master: issues ops (start, func, x, y, shamt) and receives result/flags/busy/done.
// slave : the ALU itself.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) ();

  logic             start;
  logic [3:0]       func;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] out;
  logic             carryflag;
  logic             zflag;
  logic             overflowflag;
  logic             signflag;
  logic             busy;
  logic             done;

  modport master (
    output start, func, x, y, shamt,
    input  out, carryflag, zflag, overflowflag, signflag, busy, done
  );

  modport slave (
    input  start, func, x, y, shamt,
    output out, carryflag, zflag, overflowflag, signflag, busy, done
  );

endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU with start/busy/done handshake.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SLL/SRL/SRA, reserved) finish one edge
// after launch; MUL/DIVU/REMU run on a 1-bit-per-cycle iterative engine taking
// WIDTH cycles, with busy high for the whole run.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - alu_multicycle_if.slave: start/func/x/y/shamt in;
//          out/carryflag/zflag/overflowflag/signflag/busy/done out (all registered)
module alu_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  alu_multicycle_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_OR   = 4'd3;
  localparam logic [3:0] F_XOR  = 4'd4;
  localparam logic [3:0] F_SLL  = 4'd5;
  localparam logic [3:0] F_SRL  = 4'd6;
  localparam logic [3:0] F_SRA  = 4'd7;
  localparam logic [3:0] F_MUL  = 4'd8;
  localparam logic [3:0] F_DIVU = 4'd9;
  localparam logic [3:0] F_REMU = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       f_reg;   // latched func of the running iterative op
  logic [WIDTH-1:0] a_reg;   // MUL: high accumulator, DIV: partial remainder
  logic [WIDTH-1:0] b_reg;   // MUL: multiplier/low product, DIV: dividend/quotient
  logic [WIDTH-1:0] d_reg;   // MUL: multiplicand, DIV: divisor

  // Single-cycle datapath, one extra bit carries carry/borrow/shift-out
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   sll_w;
  logic [WIDTH:0]   srl_w;
  logic [WIDTH:0]   sra_w;
  logic             add_v;
  logic             sub_v;

  assign add_w = {1'b0, bus.x} + {1'b0, bus.y};
  assign sub_w = {1'b0, bus.x} - {1'b0, bus.y};
  // Shift-out bit lands in the guard bit; shamt=0 leaves it 0
  assign sll_w = {1'b0, bus.x} << bus.shamt;
  assign srl_w = {bus.x, 1'b0} >> bus.shamt;
  assign sra_w = $unsigned($signed({bus.x, 1'b0}) >>> bus.shamt);
  assign add_v = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) & (add_w[WIDTH-1] ^ bus.x[WIDTH-1]);
  assign sub_v = (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]) & (sub_w[WIDTH-1] ^ bus.x[WIDTH-1]);

  logic [WIDTH-1:0] sc_out;
  logic             sc_c;
  logic             sc_v;

  // Single-cycle result select; reserved codes fall through to zero
  always_comb begin
    sc_out = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.func)
      F_ADD: begin sc_out = add_w[WIDTH-1:0]; sc_c = add_w[WIDTH]; sc_v = add_v; end
      F_SUB: begin sc_out = sub_w[WIDTH-1:0]; sc_c = sub_w[WIDTH]; sc_v = sub_v; end
      F_AND: sc_out = bus.x & bus.y;
      F_OR:  sc_out = bus.x | bus.y;
      F_XOR: sc_out = bus.x ^ bus.y;
      F_SLL: begin sc_out = sll_w[WIDTH-1:0]; sc_c = sll_w[WIDTH]; end
      F_SRL: begin sc_out = srl_w[WIDTH:1];   sc_c = srl_w[0];     end
      F_SRA: begin sc_out = sra_w[WIDTH:1];   sc_c = sra_w[0];     end
      default: ;
    endcase
  end

  // One shift-add multiply step: {a,b} >>= 1 after adding d when b[0]
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;

  assign mul_sum = {1'b0, a_reg} + (b_reg[0] ? {1'b0, d_reg} : '0);
  assign mul_a   = mul_sum[WIDTH:1];
  assign mul_b   = {mul_sum[0], b_reg[WIDTH-1:1]};

  // One restoring-division step: shift in next dividend bit, subtract if it fits
  logic [WIDTH:0]   div_r2;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;

  assign div_r2   = {a_reg, b_reg[WIDTH-1]};
  assign div_diff = div_r2 - {1'b0, d_reg};
  assign div_ge   = (div_r2 >= {1'b0, d_reg});
  assign div_a    = div_ge ? div_diff[WIDTH-1:0] : div_r2[WIDTH-1:0];
  assign div_b    = {b_reg[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;

  assign step_a = (f_reg == F_MUL) ? mul_a : div_a;
  assign step_b = (f_reg == F_MUL) ? mul_b : div_b;

  // Final write uses the last step directly, so FIN is also the WIDTH-th iteration
  logic [WIDTH-1:0] fin_out;
  logic             fin_v;

  always_comb begin
    fin_out = step_b;
    fin_v   = 1'b0;
    case (f_reg)
      F_MUL:  begin fin_out = step_b; fin_v = (step_a != '0); end
      F_DIVU: begin fin_out = step_b; fin_v = (d_reg == '0);  end
      F_REMU: begin fin_out = step_a; fin_v = (d_reg == '0);  end
      default: ;
    endcase
  end

  // Control FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      f_reg            <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      d_reg            <= '0;
      bus.out          <= '0;
      bus.carryflag    <= 1'b0;
      bus.zflag        <= 1'b0;
      bus.overflowflag <= 1'b0;
      bus.signflag     <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.func == F_MUL || bus.func == F_DIVU || bus.func == F_REMU) begin
              f_reg    <= bus.func;
              a_reg    <= '0;
              b_reg    <= (bus.func == F_MUL) ? bus.y : bus.x;
              d_reg    <= (bus.func == F_MUL) ? bus.x : bus.y;
              cnt      <= '0;
              bus.busy <= 1'b1;
              state    <= ITER;
            end else begin
              bus.out          <= sc_out;
              bus.carryflag    <= sc_c;
              bus.overflowflag <= sc_v;
              bus.zflag        <= (sc_out == '0);
              bus.signflag     <= sc_out[WIDTH-1];
              bus.done         <= 1'b1;
            end
          end
        end
        ITER: begin
          a_reg <= step_a;
          b_reg <= step_b;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 2)) begin
            state <= FIN;
          end
        end
        FIN: begin
          bus.out          <= fin_out;
          bus.carryflag    <= 1'b0;
          bus.overflowflag <= fin_v;
          bus.zflag        <= (fin_out == '0);
          bus.signflag     <= fin_out[WIDTH-1];
          bus.done         <= 1'b1;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: vector table plus hand-written
// sequences for busy windows, back-to-back launch and reset abort.
module tb_alu_multicycle;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = $clog2(W);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [W-1:0] out;
    logic         c;
    logic         z;
    logic         v;
    logic         s;
  } res_t;

  typedef struct {
    string name;
    res_t  r;
  } sb_t;

  typedef struct {
    string        name;
    logic [3:0]   func;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [SW-1:0] sh;
    logic [W-1:0] eout;
    logic         ec;
    logic         ev;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic res_t mk(input logic [W-1:0] o, input logic c, input logic v);
    res_t r;
    r.out = o;
    r.c   = c;
    r.z   = (o == '0);
    r.v   = v;
    r.s   = o[W-1];
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.out = bus.out;
    r.c   = bus.carryflag;
    r.z   = bus.zflag;
    r.v   = bus.overflowflag;
    r.s   = bus.signflag;
    return r;
  endfunction

  task automatic push(input string name, input res_t r);
    sb_t e;
    e.name = name;
    e.r    = r;
    sbq.push_back(e);
  endtask

  task automatic add_vec(input string name, input logic [3:0] f, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [SW-1:0] sh,
                         input logic [W-1:0] eout, input logic ec, input logic ev);
    vec_t v;
    v.name = name; v.func = f; v.x = x; v.y = y; v.sh = sh;
    v.eout = eout; v.ec = ec; v.ev = ev;
    vecs.push_back(v);
  endtask

  // Scoreboard: every done pops one expected result
  always @(posedge clk) begin : mon
    sb_t  e;
    res_t a;
    #1;
    if (!rst && bus.done) begin
      a = dut_res();
      if (sbq.size() == 0) begin
        check("unexpected_done", 1'b0, 64'(a), 64'(0));
      end else begin
        e = sbq.pop_front();
        check(e.name, a == e.r, 64'(a), 64'(e.r));
      end
    end
  end

  task automatic scramble();
    bus.x     = $urandom;
    bus.y     = $urandom;
    bus.shamt = SW'($urandom);
    bus.func  = 4'($urandom);
  endtask

  // Launch one op, scramble inputs after launch, check done latency
  task automatic run_op(input vec_t v);
    int cyc;
    int exp_lat;
    exp_lat = (v.func >= 4'd8 && v.func <= 4'd10) ? int'(W) + 1 : 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = v.func;
    bus.x     = v.x;
    bus.y     = v.y;
    bus.shamt = v.sh;
    push(v.name, mk(v.eout, v.ec, v.ev));
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        scramble();
      end
    end while (!bus.done && cyc < 80);
    check({v.name, "_lat"}, bus.done && cyc == exp_lat, 64'(cyc), 64'(exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   bad;
    vec_t v;

    bus.start = 1'b0;
    bus.func  = '0;
    bus.x     = '0;
    bus.y     = '0;
    bus.shamt = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {bus.out, bus.carryflag, bus.zflag, bus.overflowflag, bus.signflag, bus.busy, bus.done} == '0,
          64'({bus.out, bus.carryflag, bus.zflag, bus.overflowflag, bus.signflag, bus.busy, bus.done}),
          64'(0));
    rst = 1'b0;

    add_vec("add_ovf",   4'd0,  32'h7FFFFFFF, 32'h00000001, '0, 32'h80000000, 1'b0, 1'b1);
    add_vec("add_carry", 4'd0,  32'hFFFFFFFF, 32'h00000001, '0, 32'h00000000, 1'b1, 1'b0);
    add_vec("sub_borrow",4'd1,  32'h00000003, 32'h00000005, '0, 32'hFFFFFFFE, 1'b1, 1'b0);
    add_vec("sub_ovf",   4'd1,  32'h80000000, 32'h00000001, '0, 32'h7FFFFFFF, 1'b0, 1'b1);
    add_vec("and",       4'd2,  32'hF0F0F0F0, 32'hFF00FF00, '0, 32'hF000F000, 1'b0, 1'b0);
    add_vec("or",        4'd3,  32'h0F0F0000, 32'h000000F0, '0, 32'h0F0F00F0, 1'b0, 1'b0);
    add_vec("xor",       4'd4,  32'hAAAAAAAA, 32'hFFFFFFFF, '0, 32'h55555555, 1'b0, 1'b0);
    add_vec("sll_c",     4'd5,  32'h80000001, 32'h0,       5'd1, 32'h00000002, 1'b1, 1'b0);
    add_vec("sll_0",     4'd5,  32'h80000001, 32'h0,       5'd0, 32'h80000001, 1'b0, 1'b0);
    add_vec("srl_c",     4'd6,  32'h80000010, 32'h0,       5'd5, 32'h04000000, 1'b1, 1'b0);
    add_vec("sra",       4'd7,  32'h80000000, 32'h0,       5'd4, 32'hF8000000, 1'b0, 1'b0);
    add_vec("sra_c",     4'd7,  32'h80000008, 32'h0,       5'd4, 32'hF8000000, 1'b1, 1'b0);
    add_vec("rsvd12",    4'd12, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h0,       1'b0, 1'b0);
    add_vec("rsvd15",    4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h0,       1'b0, 1'b0);
    add_vec("mul_hi",    4'd8,  32'h00010000, 32'h00010000, '0, 32'h00000000, 1'b0, 1'b1);
    add_vec("mul_small", 4'd8,  32'h00001234, 32'h00000010, '0, 32'h00012340, 1'b0, 1'b0);
    add_vec("mul_max",   4'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, '0, 32'h00000001, 1'b0, 1'b1);
    add_vec("divu",      4'd9,  32'd100,      32'd7,        '0, 32'd14,       1'b0, 1'b0);
    add_vec("remu",      4'd10, 32'd100,      32'd7,        '0, 32'd2,        1'b0, 1'b0);
    add_vec("divu_z",    4'd9,  32'd5,        32'd0,        '0, 32'hFFFFFFFF, 1'b0, 1'b1);
    add_vec("remu_z",    4'd10, 32'd5,        32'd0,        '0, 32'd5,        1'b0, 1'b1);
    add_vec("divu_big",  4'd9,  32'hFFFFFFFF, 32'd1,        '0, 32'hFFFFFFFF, 1'b0, 1'b0);
    add_vec("remu_big",  4'd10, 32'hFFFFFFFF, 32'h00010000, '0, 32'h0000FFFF, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i]);
    end

    // MUL busy window, ignored start while busy, start accepted in done cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = 4'd8;
    bus.x     = 32'h00010000;
    bus.y     = 32'h00010000;
    push("mul_hs", mk(32'h0, 1'b0, 1'b1));
    bad = 0;
    for (int k = 1; k <= int'(W); k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        bus.start = 1'b0;
        scramble();
      end
      if (!(bus.busy && !bus.done)) bad++;
      if (k == 5) begin
        bus.start = 1'b1;
        bus.func  = 4'd0;
        bus.x     = 32'd1;
        bus.y     = 32'd1;
      end
      if (k == 6) bus.start = 1'b0;
    end
    check("mul_busy_window", bad == 0, 64'(bad), 64'(0));
    @(posedge clk);
    #1;
    check("mul_done_n33", bus.done && !bus.busy, 64'({bus.done, bus.busy}), 64'(2'b10));
    bus.start = 1'b1;
    bus.func  = 4'd0;
    bus.x     = 32'd2;
    bus.y     = 32'd2;
    push("add_in_done_cycle", mk(32'd4, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("add_in_done_cycle_lat", bus.done, 64'(bus.done), 64'(1));
    bus.start = 1'b0;

    // Reset aborts a DIVU in flight; no done afterwards
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = 4'd9;
    bus.x     = 32'd100;
    bus.y     = 32'd7;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.start = 1'b0;
    end
    check("divu_busy_before_rst", bus.busy, 64'(bus.busy), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_abort", bus.out == '0 && !bus.busy && !bus.done,
          64'({bus.out, bus.busy, bus.done}), 64'(0));
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_abort", !bus.busy && !bus.done, 64'({bus.busy, bus.done}), 64'(0));

    v.name = "add_after_rst"; v.func = 4'd0; v.x = 32'd2; v.y = 32'd2; v.sh = '0;
    v.eout = 32'd4; v.ec = 1'b0; v.ev = 1'b0;
    run_op(v);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_empty", sbq.size() == 0, 64'(sbq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
